secuenciador_credito: RTL and testbench
=======================================

SECUENCIADOR_CREDITO -- requirements
Module: secuenciador_credito

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 16, clk cycles spent in each intermediate state (legal range 1..255).
REQ-002 SHALL have the following ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sw_credito  input  4  credit amount added on each carga event.
- carga  input  1  asynchronous level; a rising edge loads credit.
- avance  input  1  asynchronous level; a rising edge starts a run.
- estado_obj  input  3  target state; sampled when a run starts.
- estado_actual  output  4  current state 0..7; bit 3 is always 0.
- credito_ok  output  1  high while credit count > 0.
- ocupado  output  1  high in every FSM state except REPOSO.
- fin  output  1  one-cycle pulse when the target is reached.
- sin_credito  output  1  sticky flag: a run stopped for lack of credit.
- seg  output  7  7-segment code of estado_actual, seg[0]=a .. seg[6]=g, active-high.

Function
REQ-003 SHALL pass carga and avance each through a 2-FF synchronizer, then a rising-edge detector (a third FF); each detected edge is one event.
REQ-004 SHALL hold a 4-bit credit counter:
- a carga event adds sw_credito, saturating at 15;
- each AVANZA cycle subtracts 1;
- if both occur in the same cycle, the result is count + sw_credito - 1, saturating at 15.
REQ-005 credito_ok SHALL be registered and equal (credit counter != 0).
REQ-006 SHALL implement FSM states REPOSO, AVANZA, ESPERA and FIN.
REQ-007 REPOSO transitions:
- avance event with credit > 0 and estado_obj != estado_actual[2:0]: latch estado_obj, clear sin_credito, go to AVANZA.
- any other avance event: ignored, stay in REPOSO.
REQ-008 AVANZA SHALL last exactly one cycle:
- estado_actual[2:0] increments by 1, wrapping 7 -> 0;
- credit decrements by 1;
- dwell counter loads DWELL_CYCLES-1;
- next state is ESPERA.
REQ-009 ESPERA SHALL decrement the dwell counter each cycle. When it reaches 0:
- estado_actual equals the latched target: go to FIN;
- otherwise, credit > 0: go to AVANZA;
- otherwise: set sin_credito and go to REPOSO.
REQ-010 FIN SHALL assert fin for exactly one cycle, then go to REPOSO.
REQ-011 avance events outside REPOSO SHALL be ignored. estado_obj changes during a run SHALL be ignored.
REQ-012 Latency: estado_actual SHALL first change on the 4th rising clk edge at which avance is sampled high (the first sampling edge counts as 1).
REQ-013 Each intermediate state SHALL be held for exactly DWELL_CYCLES+1 cycles (1 in AVANZA plus DWELL_CYCLES in ESPERA).

Reset
REQ-014 rst high SHALL immediately and asynchronously force:
- FSM to REPOSO;
- estado_actual, credit, dwell counter and synchronizer FFs to 0;
- credito_ok, ocupado, fin and sin_credito to 0;
- seg to the code for 0 (7'h3F when DISPLAY7SEG_EN is defined, else 0).
REQ-015 Reset asserted mid-run SHALL abandon the run. After rst deasserts, no event SHALL be generated from inputs already high.

Configuration
REQ-016 With macro DISPLAY7SEG_EN defined, seg SHALL be a registered decode of estado_actual: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07 (hex). seg SHALL update one cycle after estado_actual.
REQ-017 Without DISPLAY7SEG_EN, seg SHALL be constant 0 and no decoder logic SHALL be present. All other behaviour is identical.

Verification
REQ-018 Reset, sw_credito=3, one carga pulse -> credito_ok=1 and credit=3 within 3 cycles; estado_actual=0, seg=3F.
REQ-019 Credit=3, estado_obj=2, avance pulse, DWELL_CYCLES=4 -> estado_actual steps 1 then 2, each held 5 cycles; fin pulses once; credit=1; ocupado returns to 0.
REQ-020 Credit=1, estado_obj=3 from state 0 -> estado_actual stops at 1, sin_credito=1, fin never pulses, FSM returns to REPOSO.
REQ-021 Credit=15 plus a carga with sw_credito=15 -> credit saturates at 15. carga during AVANZA with sw_credito=2 and credit=5 -> credit=6.
REQ-022 estado_actual=6, estado_obj=1, credit=4 -> sequence 7, 0, 1 (wrap); fin pulses; avance pulses sent mid-run are ignored.
REQ-023 rst asserted during ESPERA -> all outputs reach reset values before the next clk edge. With DISPLAY7SEG_EN undefined, seg stays 0 throughout all scenarios.

Source files
------------

// File: rtl/secuenciador_credito.sv
// secuenciador_credito: credit-limited stepper that walks estado_actual toward a target, dwelling in each state.
// Optional 7-segment decode of estado_actual is enabled with macro DISPLAY7SEG_EN.
module secuenciador_credito #(
  parameter int DWELL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_credito,
  input  logic       carga,
  input  logic       avance,
  input  logic [2:0] estado_obj,
  output logic [3:0] estado_actual,
  output logic       credito_ok,
  output logic       ocupado,
  output logic       fin,
  output logic       sin_credito,
  output logic [6:0] seg
);
  typedef enum logic [1:0] {REPOSO, AVANZA, ESPERA, FIN} estado_t;
  estado_t st, st_n;
  logic [2:0] c_s, a_s, est, obj;
  logic [1:0] arm;
  logic [3:0] credito;
  logic [7:0] dwell;
  logic [4:0] suma;
  logic ev_carga, ev_avance, inicio, agotado;
  // Edges are masked until the edge detectors have refilled after reset, so levels held through reset never fire.
  assign ev_carga  = c_s[1] & ~c_s[2] & (arm == 2'd3);
  assign ev_avance = a_s[1] & ~a_s[2] & (arm == 2'd3);
  assign inicio    = ev_avance && st == REPOSO && credito != 4'd0 && estado_obj != est;
  assign agotado   = st == ESPERA && dwell == 8'd0 && est != obj && credito == 4'd0;
  assign suma      = {1'b0, credito} + (ev_carga ? {1'b0, sw_credito} : 5'd0) - {4'd0, st == AVANZA};
  assign estado_actual = {1'b0, est};
  assign ocupado = st != REPOSO;
  assign fin     = st == FIN;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= REPOSO;
    else st <= st_n;
  always_comb begin
    st_n = st;
    case (st)
      REPOSO: st_n = inicio ? AVANZA : REPOSO;
      AVANZA: st_n = ESPERA;
      ESPERA: st_n = dwell != 8'd0 ? ESPERA : est == obj ? FIN : credito != 4'd0 ? AVANZA : REPOSO;
      FIN:    st_n = REPOSO;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c_s         <= '0;
      a_s         <= '0;
      arm         <= '0;
      credito     <= '0;
      credito_ok  <= 1'b0;
      est         <= '0;
      obj         <= '0;
      dwell       <= '0;
      sin_credito <= 1'b0;
    end else begin
      c_s        <= {c_s[1:0], carga};
      a_s        <= {a_s[1:0], avance};
      arm        <= arm == 2'd3 ? arm : arm + 2'd1;
      credito    <= suma[4] ? 4'hF : suma[3:0];
      credito_ok <= suma != 5'd0;
      if (inicio) obj <= estado_obj;
      if (st == AVANZA) begin
        est   <= est + 3'd1;
        dwell <= 8'(DWELL_CYCLES - 1);
      end else if (st == ESPERA && dwell != 8'd0) dwell <= dwell - 8'd1;
      sin_credito <= inicio ? 1'b0 : agotado ? 1'b1 : sin_credito;
    end
`ifdef DISPLAY7SEG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) seg <= 7'h3F;
    else
      case (est)
        3'd0: seg <= 7'h3F;
        3'd1: seg <= 7'h06;
        3'd2: seg <= 7'h5B;
        3'd3: seg <= 7'h4F;
        3'd4: seg <= 7'h66;
        3'd5: seg <= 7'h6D;
        3'd6: seg <= 7'h7D;
        default: seg <= 7'h07;
      endcase
`else
  assign seg = '0;
`endif
endmodule

// File: tb/tb_secuenciador_credito.sv
// tb_secuenciador_credito: scoreboard bench; expected state steps are queued as runs are launched.
module tb_secuenciador_credito;
  localparam int DW = 4;
  logic clk = 0, rst = 1, carga = 0, avance = 0;
  logic [3:0] sw_credito = 0;
  logic [2:0] estado_obj = 0;
  logic [3:0] estado_actual;
  logic credito_ok, ocupado, fin, sin_credito;
  logic [6:0] seg;
  int total = 0, bad = 0, fin_cnt = 0, hold = 0;
  logic [2:0] prev_est = 0, e;
  logic seen_first = 0, prev_fin = 0;
  logic [2:0] exp_q[$];
  secuenciador_credito #(.DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst(rst), .sw_credito(sw_credito), .carga(carga), .avance(avance),
    .estado_obj(estado_obj), .estado_actual(estado_actual), .credito_ok(credito_ok),
    .ocupado(ocupado), .fin(fin), .sin_credito(sin_credito), .seg(seg)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] seg_exp(input logic [2:0] v);
`ifdef DISPLAY7SEG_EN
    logic [6:0] t [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
    return t[v];
`else
    return 7'h00 | {4'd0, v & 3'd0};
`endif
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      prev_est = 0;
      seen_first = 0;
      prev_fin = 0;
    end else begin
      total++;
      if (seg !== seg_exp(prev_est)) begin bad++; $display("FAIL seg: got %h expected %h", seg, seg_exp(prev_est)); end
      if (estado_actual !== {1'b0, prev_est}) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL step: unexpected change to %0d", estado_actual); end
        else begin
          e = exp_q.pop_front();
          if (estado_actual !== {1'b0, e}) begin bad++; $display("FAIL step: got %0d expected %0d", estado_actual, e); end
        end
        if (seen_first) begin
          total++;
          if (hold != DW + 1) begin bad++; $display("FAIL hold: got %0d expected %0d", hold, DW + 1); end
        end
        seen_first = 1;
        hold = 1;
      end else hold++;
      if (fin) begin
        fin_cnt++;
        total++;
        if (prev_fin) begin bad++; $display("FAIL fin_width: got 2+ cycles expected 1"); end
      end
      prev_fin = fin;
      prev_est = estado_actual[2:0];
    end
  end
  task automatic do_carga(input logic [3:0] sw);
    @(posedge clk); #1;
    sw_credito = sw;
    carga = 1;
    repeat (2) @(posedge clk);
    #1 carga = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic do_avance(input logic [2:0] o);
    @(posedge clk); #1;
    seen_first = 0;
    estado_obj = o;
    avance = 1;
    repeat (2) @(posedge clk);
    #1 avance = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    repeat (4) @(posedge clk);
    #1;
    while (ocupado && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 500) begin bad++; $display("FAIL idle_timeout: ocupado=%b expected 0", ocupado); end
  endtask
  task automatic push_steps(input logic [2:0] from, input logic [2:0] to);
    for (logic [2:0] s = from + 3'd1; s != to; s++) exp_q.push_back(s);
    exp_q.push_back(to);
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (estado_actual !== 4'd0) begin bad++; $display("FAIL rst_est: got %0d expected 0", estado_actual); end
    total++; if ({credito_ok, ocupado, fin, sin_credito} !== 4'b0) begin bad++; $display("FAIL rst_flags: got %b expected 0000", {credito_ok, ocupado, fin, sin_credito}); end
    total++; if (seg !== seg_exp(3'd0)) begin bad++; $display("FAIL rst_seg: got %h expected %h", seg, seg_exp(3'd0)); end
    rst = 0;
  endtask
  task automatic test_carga();
    @(posedge clk); #1;
    sw_credito = 3;
    carga = 1;
    repeat (3) @(posedge clk);
    #1 carga = 0;
    total++; if (dut.credito !== 4'd3) begin bad++; $display("FAIL carga_credit: got %0d expected 3", dut.credito); end
    total++; if (credito_ok !== 1'b1) begin bad++; $display("FAIL carga_ok: got %b expected 1", credito_ok); end
    total++; if (estado_actual !== 4'd0) begin bad++; $display("FAIL carga_est: got %0d expected 0", estado_actual); end
    repeat (3) @(posedge clk);
  endtask
  task automatic test_run();
    int k = 0, f0 = fin_cnt;
    @(posedge clk); #1;
    seen_first = 0;
    push_steps(3'd0, 3'd2);
    estado_obj = 2;
    avance = 1;
    while (estado_actual == 4'd0 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    avance = 0;
    total++; if (k != 4) begin bad++; $display("FAIL latency: got %0d edges expected 4", k); end
    wait_idle();
    total++; if (estado_actual !== 4'd2) begin bad++; $display("FAIL run_est: got %0d expected 2", estado_actual); end
    total++; if (fin_cnt - f0 != 1) begin bad++; $display("FAIL run_fin: got %0d pulses expected 1", fin_cnt - f0); end
    total++; if (dut.credito !== 4'd1) begin bad++; $display("FAIL run_credit: got %0d expected 1", dut.credito); end
    total++; if (sin_credito !== 1'b0) begin bad++; $display("FAIL run_sin: got %b expected 0", sin_credito); end
  endtask
  task automatic test_sin_credito();
    int f0;
    rst = 1;
    @(posedge clk); #1 rst = 0;
    do_carga(1);
    f0 = fin_cnt;
    push_steps(3'd0, 3'd1);
    do_avance(3);
    wait_idle();
    total++; if (estado_actual !== 4'd1) begin bad++; $display("FAIL nocred_est: got %0d expected 1", estado_actual); end
    total++; if (sin_credito !== 1'b1) begin bad++; $display("FAIL nocred_flag: got %b expected 1", sin_credito); end
    total++; if (fin_cnt != f0) begin bad++; $display("FAIL nocred_fin: got %0d pulses expected 0", fin_cnt - f0); end
    total++; if (credito_ok !== 1'b0) begin bad++; $display("FAIL nocred_ok: got %b expected 0", credito_ok); end
    do_avance(5);
    wait_idle();
    total++; if (estado_actual !== 4'd1) begin bad++; $display("FAIL nocred_ignore: got %0d expected 1", estado_actual); end
  endtask
  task automatic test_saturacion();
    rst = 1;
    @(posedge clk); #1 rst = 0;
    do_carga(15);
    do_carga(15);
    total++; if (dut.credito !== 4'd15) begin bad++; $display("FAIL sat: got %0d expected 15", dut.credito); end
    rst = 1;
    @(posedge clk); #1 rst = 0;
    do_carga(5);
    push_steps(3'd0, 3'd1);
    @(posedge clk); #1;
    seen_first = 0;
    estado_obj = 1;
    avance = 1;
    sw_credito = 2;
    @(posedge clk); #1 carga = 1;
    @(posedge clk); #1 avance = 0;
    @(posedge clk); #1 carga = 0;
    wait_idle();
    total++; if (dut.credito !== 4'd6) begin bad++; $display("FAIL carga_avanza: got %0d expected 6", dut.credito); end
    do_avance(1);
    wait_idle();
    total++; if (estado_actual !== 4'd1 || dut.credito !== 4'd6) begin bad++; $display("FAIL same_target: got est=%0d credit=%0d expected 1/6", estado_actual, dut.credito); end
  endtask
  task automatic test_wrap();
    int f0;
    push_steps(3'd1, 3'd6);
    do_avance(6);
    wait_idle();
    do_carga(3);
    total++; if (estado_actual !== 4'd6 || dut.credito !== 4'd4) begin bad++; $display("FAIL wrap_setup: got est=%0d credit=%0d expected 6/4", estado_actual, dut.credito); end
    f0 = fin_cnt;
    push_steps(3'd6, 3'd1);
    do_avance(1);
    repeat (2) begin
      repeat (4) @(posedge clk);
      #1 estado_obj = 4;
      avance = 1;
      repeat (2) @(posedge clk);
      #1 avance = 0;
    end
    wait_idle();
    total++; if (estado_actual !== 4'd1) begin bad++; $display("FAIL wrap_est: got %0d expected 1", estado_actual); end
    total++; if (fin_cnt - f0 != 1) begin bad++; $display("FAIL wrap_fin: got %0d pulses expected 1", fin_cnt - f0); end
    total++; if (dut.credito !== 4'd1) begin bad++; $display("FAIL wrap_credit: got %0d expected 1", dut.credito); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    do_carga(5);
    push_steps(3'd1, 3'd4);
    do_avance(4);
    while (estado_actual != 4'd2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (n >= 50) begin bad++; $display("FAIL mid_timeout: got est=%0d expected 2", estado_actual); end
    @(posedge clk); #2 rst = 1;
    #1;
    total++; if (estado_actual !== 4'd0 || dut.credito !== 4'd0) begin bad++; $display("FAIL mid_rst_state: got est=%0d credit=%0d expected 0/0", estado_actual, dut.credito); end
    total++; if ({credito_ok, ocupado, fin, sin_credito} !== 4'b0) begin bad++; $display("FAIL mid_rst_flags: got %b expected 0000", {credito_ok, ocupado, fin, sin_credito}); end
    total++; if (seg !== seg_exp(3'd0)) begin bad++; $display("FAIL mid_rst_seg: got %h expected %h", seg, seg_exp(3'd0)); end
    exp_q.delete();
    sw_credito = 5;
    carga = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (dut.credito !== 4'd0 || credito_ok !== 1'b0) begin bad++; $display("FAIL held_level: got credit=%0d expected 0", dut.credito); end
    carga = 0;
    do_carga(2);
    total++; if (dut.credito !== 4'd2) begin bad++; $display("FAIL post_rst_carga: got %0d expected 2", dut.credito); end
  endtask
  initial begin
    test_reset();
    test_carga();
    test_run();
    test_sin_credito();
    test_saturacion();
    test_wrap();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL pending_steps: got %0d expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
